// File: rtl/fetch_decode_queue_pkg.sv
// Shared packet layout and constants for the fetch/decode boundary queue.
package fetch_decode_queue_pkg;

  localparam int GHR_W       = 4;
  localparam int FETCH_PKT_W = 101;

  localparam int PKT_PC_LSB      = 0;
  localparam int PKT_INSTR_LSB   = 32;
  localparam int PKT_PRED_PC_LSB = 64;
  localparam int PKT_GHR_LSB     = 96;
  localparam int PKT_PRED_VALID  = 100;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Packed MSB-first, so pc lands in [31:0] and pred_valid in [100].
  typedef struct packed {
    logic             pred_valid;
    logic [GHR_W-1:0] ghr;
    logic [31:0]      pred_pc;
    logic [31:0]      instr;
    logic [31:0]      pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fdq_storage.sv
// Packet register array: one synchronous write port, one asynchronous read port.
module fdq_storage
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = FETCH_PKT_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // No reset: the top masks the read data whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// Elastic IF/ID queue: first-word-fall-through FIFO of fetch packets with flush.
module fetch_decode_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = fetch_decode_queue_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pred_pc,
  input  logic [3:0]                 in_ghr,
  input  logic                       in_pred_valid,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pred_pc,
  output logic [3:0]                 out_ghr,
  output logic                       out_pred_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  import fetch_decode_queue_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic       not_empty;
  logic       push, pop;
  fetch_pkt_t wr_pkt, rd_pkt;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = not_empty & ~flush;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  assign wr_pkt.pc         = in_pc;
  assign wr_pkt.instr      = in_instr;
  assign wr_pkt.pred_pc    = in_pred_pc;
  assign wr_pkt.ghr        = in_ghr;
  assign wr_pkt.pred_valid = in_pred_valid;

  fdq_storage #(
    .DEPTH (DEPTH),
    .W     (FETCH_PKT_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_pkt),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_pkt)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty slots may hold stale or uninitialised data, so mask on occupancy.
  assign out_pc         = not_empty ? rd_pkt.pc         : '0;
  assign out_instr      = not_empty ? rd_pkt.instr      : NOP_INSTR;
  assign out_pred_pc    = not_empty ? rd_pkt.pred_pc    : '0;
  assign out_ghr        = not_empty ? rd_pkt.ghr        : '0;
  assign out_pred_valid = not_empty ? rd_pkt.pred_valid : 1'b0;
  assign count          = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios then random traffic vs a queue model.
module tb_fetch_decode_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [31:0]   in_pc, in_instr, in_pred_pc;
  logic [3:0]    in_ghr;
  logic          in_pred_valid;
  logic          flush;
  logic          out_valid, out_ready;
  logic [31:0]   out_pc, out_instr, out_pred_pc;
  logic [3:0]    out_ghr;
  logic          out_pred_valid;
  logic [CW-1:0] count;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pred_pc;
    logic [3:0]  ghr;
    logic        pv;
  } pkt_t;

  pkt_t model_q[$];

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .in_pred_pc     (in_pred_pc),
    .in_ghr         (in_ghr),
    .in_pred_valid  (in_pred_valid),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_pred_pc    (out_pred_pc),
    .out_ghr        (out_ghr),
    .out_pred_valid (out_pred_valid),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0000_0013);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pred_pc", out_pred_pc, 32'd0);
    chk("rst_out_ghr", 32'(out_ghr), 32'd0);
    chk("rst_out_pred_valid", 32'(out_pred_valid), 32'd0);
  endtask

  task automatic check_outputs();
    bit   has;
    pkt_t h;
    has = (model_q.size() != 0);
    h   = '{pc: 32'd0, instr: 32'h0000_0013, pred_pc: 32'd0, ghr: 4'd0, pv: 1'b0};
    if (has) h = model_q[0];
    chk("out_valid", 32'(out_valid), 32'(has && !flush));
    chk("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
    chk("count", 32'(count), 32'(model_q.size()));
    chk("out_pc", out_pc, h.pc);
    chk("out_instr", out_instr, h.instr);
    chk("out_pred_pc", out_pred_pc, h.pred_pc);
    chk("out_ghr", 32'(out_ghr), 32'(h.ghr));
    chk("out_pred_valid", 32'(out_pred_valid), 32'(h.pv));
  endtask

  // Called one time unit after a rising edge; leaves one unit after the next.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                     input logic [31:0] pred, input logic [3:0] ghr, input logic pv,
                     input logic fl, input logic rdy);
    bit   do_push, do_pop;
    pkt_t p;
    in_valid      = v;
    in_pc         = pc;
    in_instr      = instr;
    in_pred_pc    = pred;
    in_ghr        = ghr;
    in_pred_valid = pv;
    flush         = fl;
    out_ready     = rdy;
    #3;
    check_outputs();
    do_push = v && (model_q.size() < DEPTH) && !fl;
    do_pop  = (model_q.size() != 0) && !fl && rdy;
    p = '{pc: pc, instr: instr, pred_pc: pred, ghr: ghr, pv: pv};
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(p);
    end
    #1;
  endtask

  task automatic push_simple(input logic [31:0] pc, input logic [31:0] instr, input logic rdy);
    cyc(1'b1, pc, instr, pc + 32'd4, pc[5:2], pc[2], 1'b0, rdy);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_instr = '0; in_pred_pc = '0;
    in_ghr = '0; in_pred_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #3;
    check_reset_values();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(1'b1);
    idle(1'b0);

    push_simple(32'h0, 32'h0050_0093, 1'b1);
    push_simple(32'h4, 32'h00A0_0113, 1'b1);
    idle(1'b1);
    idle(1'b1);

    push_simple(32'h8, 32'h1111_1111, 1'b0);
    push_simple(32'hC, 32'h2222_2222, 1'b0);
    push_simple(32'h10, 32'h3333_3333, 1'b0);
    push_simple(32'h10, 32'h3333_3333, 1'b1);
    push_simple(32'h10, 32'h3333_3333, 1'b1);
    idle(1'b1);
    idle(1'b1);

    push_simple(32'h20, 32'h4444_4444, 1'b0);
    push_simple(32'h24, 32'h5555_5555, 1'b0);
    cyc(1'b1, 32'h28, 32'h6666_6666, 32'h2C, 4'h3, 1'b1, 1'b1, 1'b1);
    push_simple(32'h40, 32'h7777_7777, 1'b0);
    idle(1'b1);
    idle(1'b1);

    push_simple(32'h100, 32'h8888_0000, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 32'h100 + 32'(4 * i), 32'h8888_0000 + 32'(i), 32'h104 + 32'(4 * i),
          4'hA, 1'b1, 1'b0, 1'b1);
    end
    idle(1'b1);
    idle(1'b1);

    push_simple(32'h300, 32'h9999_0001, 1'b0);
    push_simple(32'h304, 32'h9999_0002, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    model_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_simple(32'h200, 32'hAAAA_BBBB, 1'b0);
    idle(1'b1);
    idle(1'b1);

    for (int i = 0; i < 500; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, 4'($urandom),
          1'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
